// File: rtl/loader_pkg.sv
// Shared types for the download-to-SDRAM loader:
// FSM state enum, FIFO entry layout, strobe gap length.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ACK,
    S_DONE,
    S_GAP
  } loader_state_t;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } entry_t;

  localparam int ENTRY_W    = $bits(entry_t);
  localparam int GAP_CYCLES = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear.
// Ports: clk, clr, push/wdata, pop/rdata (head), count, full, empty.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);

endmodule

// File: rtl/ram_loader.sv
// Replays buffered download bytes as SDRAM misc-port writes,
// plus one read-back path.
// Ports: clk, init (sync reset); ioctl_* download stream;
// rd_req/rd_addr -> rd_data/rd_valid; busy, overflow;
// misc_* controller port (edge-triggered strobes, misc_ready).
module ram_loader
  import loader_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [24:0] ADDR_BASE  = 25'h0
) (
  input  logic        clk,
  input  logic        init,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        rd_req,
  input  logic [24:0] rd_addr,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        overflow,
  output logic [24:0] misc_addr,
  output logic [7:0]  misc_din,
  input  logic [7:0]  misc_dout,
  output logic        misc_rd,
  output logic        misc_we,
  input  logic        misc_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);

  loader_state_t state, state_n;

  logic        kind, kind_n;
  logic [1:0]  gap_cnt, gap_n;
  logic        we_n, rd_n;
  logic [24:0] addr_n;
  logic [7:0]  din_n;
  logic [7:0]  rdata_n;
  logic        rvalid_n;
  logic        pop;
  logic        pend_clr;

  logic        rd_pend;
  logic [24:0] rd_pend_addr;
  logic        dl_q;

  entry_t      wr_entry;
  entry_t      head;
  logic [AW:0] fifo_count;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        drop;

  // A full FIFO still takes a byte if the head leaves on the same edge.
  assign push = ioctl_wr && (!fifo_full || pop);
  assign drop = ioctl_wr && fifo_full && !pop;

  assign wr_entry.addr = ioctl_addr + ADDR_BASE;
  assign wr_entry.data = ioctl_dout;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clr   (init),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign busy = (fifo_count != '0)
             || (state != S_IDLE)
             || rd_pend;

  // kind: 0 = write, 1 = read
  always_comb begin
    state_n  = state;
    kind_n   = kind;
    gap_n    = gap_cnt;
    we_n     = misc_we;
    rd_n     = misc_rd;
    addr_n   = misc_addr;
    din_n    = misc_din;
    rdata_n  = rd_data;
    rvalid_n = 1'b0;
    pop      = 1'b0;
    pend_clr = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          addr_n  = head.addr;
          din_n   = head.data;
          kind_n  = 1'b0;
          state_n = S_ISSUE;
        end else if (rd_pend) begin
          addr_n   = rd_pend_addr;
          pend_clr = 1'b1;
          kind_n   = 1'b1;
          state_n  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        we_n    = !kind;
        rd_n    = kind;
        state_n = S_ACK;
      end
      // misc_ready is registered in the controller; it is still
      // high here from the previous transaction.
      S_ACK: state_n = S_DONE;
      S_DONE: begin
        if (misc_ready) begin
          we_n    = 1'b0;
          rd_n    = 1'b0;
          gap_n   = 2'(GAP_CYCLES - 1);
          state_n = S_GAP;
          if (kind) begin
            rdata_n  = misc_dout;
            rvalid_n = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) state_n = S_IDLE;
        else gap_n = gap_cnt - 2'd1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state     <= S_IDLE;
      kind      <= 1'b0;
      gap_cnt   <= '0;
      misc_we   <= 1'b0;
      misc_rd   <= 1'b0;
      misc_addr <= '0;
      misc_din  <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      state     <= state_n;
      kind      <= kind_n;
      gap_cnt   <= gap_n;
      misc_we   <= we_n;
      misc_rd   <= rd_n;
      misc_addr <= addr_n;
      misc_din  <= din_n;
      rd_data   <= rdata_n;
      rd_valid  <= rvalid_n;
    end
  end

  // A request colliding with the IDLE pick-up sees rd_pend=1
  // and is dropped.
  always_ff @(posedge clk) begin
    if (init) begin
      rd_pend      <= 1'b0;
      rd_pend_addr <= '0;
    end else if (pend_clr) begin
      rd_pend <= 1'b0;
    end else if (rd_req && !rd_pend) begin
      rd_pend      <= 1'b1;
      rd_pend_addr <= rd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      overflow <= 1'b0;
      dl_q     <= 1'b0;
    end else begin
      dl_q <= ioctl_download;
      if (drop)
        overflow <= 1'b1;
      else if (ioctl_download && !dl_q)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: misc-port controller model,
// transaction-level expectation model, directed tests.
module tb_ram_loader;

  localparam int SVC = 7;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        init;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic        wr_b;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        rd_req;
  logic        rd_req_b;
  logic [24:0] rd_addr;
  logic        stall;

  logic [7:0]  rd_data, rd_data_b;
  logic        rd_valid, rd_valid_b;
  logic        busy, busy_b;
  logic        overflow, overflow_b;
  logic [24:0] misc_addr, misc_addr_b;
  logic [7:0]  misc_din, misc_din_b;
  logic [7:0]  misc_dout;
  logic [7:0]  misc_dout_b;
  logic        misc_rd, misc_rd_b;
  logic        misc_we, misc_we_b;
  logic        rdy = 1'b1;
  logic        rdy_b = 1'b1;

  ram_loader #(.FIFO_DEPTH(4), .ADDR_BASE(25'h0)) dut (
    .clk(clk), .init(init), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .overflow(overflow), .misc_addr(misc_addr),
    .misc_din(misc_din), .misc_dout(misc_dout),
    .misc_rd(misc_rd), .misc_we(misc_we), .misc_ready(rdy)
  );

  ram_loader #(.FIFO_DEPTH(4), .ADDR_BASE(25'h1FFFFF0)) dut_b (
    .clk(clk), .init(init), .ioctl_download(ioctl_download),
    .ioctl_wr(wr_b), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .rd_req(rd_req_b), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .busy(busy_b),
    .overflow(overflow_b), .misc_addr(misc_addr_b),
    .misc_din(misc_din_b), .misc_dout(misc_dout_b),
    .misc_rd(misc_rd_b), .misc_we(misc_we_b), .misc_ready(rdy_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: ready drops the cycle after a strobe rise,
  // returns SVC cycles later (frozen while stall=1).
  logic [7:0] sd_mem [4096];
  logic       c_prev = 1'b0;
  int         c_cnt = 0;
  logic       cb_prev = 1'b0;
  int         cb_cnt = 0;

  assign misc_dout   = sd_mem[misc_addr[11:0]];
  assign misc_dout_b = 8'h00;

  always @(posedge clk) begin
    c_prev <= misc_we | misc_rd;
    if ((misc_we | misc_rd) && !c_prev) begin
      rdy   <= 1'b0;
      c_cnt <= SVC;
      if (misc_we) sd_mem[misc_addr[11:0]] <= misc_din;
    end else if (c_cnt > 0 && !stall) begin
      c_cnt <= c_cnt - 1;
      if (c_cnt == 1) rdy <= 1'b1;
    end
  end

  always @(posedge clk) begin
    cb_prev <= misc_we_b | misc_rd_b;
    if ((misc_we_b | misc_rd_b) && !cb_prev) begin
      rdy_b  <= 1'b0;
      cb_cnt <= SVC;
    end else if (cb_cnt > 0) begin
      cb_cnt <= cb_cnt - 1;
      if (cb_cnt == 1) rdy_b <= 1'b1;
    end
  end

  // Expectation model
  typedef struct {
    logic [24:0] a;
    logic [7:0]  d;
  } wexp_t;

  wexp_t       wq[$];
  logic [7:0]  pmem [4096];
  bit          rp_v = 1'b0;
  logic [24:0] rp_addr;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Compare process state
  bit          chk_en = 1'b0;
  logic        prev_st = 1'b0;
  bit          cur_rd;
  logic [24:0] cur_addr;
  logic [7:0]  cur_din;
  bit          stalled;
  int          hi_len = 0;
  int          last_hi = 0;
  int          low_len = 100;
  int          rise_cyc = 0;
  int          rise_cnt = 0;
  int          wr_seen = 0;
  int          rv_cnt = 0;
  logic [7:0]  last_rdata;

  always @(negedge clk) begin
    logic st;
    bit   rv_exp;
    st = misc_we | misc_rd;
    rv_exp = 1'b0;
    if (init || !chk_en) begin
      prev_st = 1'b0;
      low_len = 100;
    end else begin
      if (misc_we && misc_rd) chk("both_strobes", 1, 0);
      if (st && !prev_st) begin
        rise_cyc = cyc;
        rise_cnt++;
        if (low_len < GAP) chk("gap_len", low_len, GAP);
        hi_len  = 1;
        stalled = stall;
        if (wq.size() > 0) begin
          wexp_t e;
          e = wq.pop_front();
          cur_rd   = 1'b0;
          cur_addr = e.a;
          cur_din  = e.d;
          wr_seen++;
          chk("rise_we", misc_we, 1);
          chk("rise_addr", misc_addr, e.a);
          chk("rise_din", misc_din, e.d);
        end else if (rp_v) begin
          cur_rd   = 1'b1;
          cur_addr = rp_addr;
          rp_v     = 1'b0;
          chk("rise_rd", misc_rd, 1);
          chk("rise_raddr", misc_addr, rp_addr);
        end else begin
          chk("unexp_strobe", st, 0);
        end
      end else if (st) begin
        hi_len++;
        if (stall) stalled = 1'b1;
        if (misc_addr !== cur_addr)
          chk("hold_addr", misc_addr, cur_addr);
        if (!cur_rd && misc_din !== cur_din)
          chk("hold_din", misc_din, cur_din);
        if (misc_we !== !cur_rd)
          chk("hold_kind", misc_we, !cur_rd);
      end else if (prev_st) begin
        if (!stalled) chk("hi_len", hi_len, 2 + SVC);
        last_hi = hi_len;
        rv_exp  = cur_rd;
        low_len = 1;
      end else begin
        low_len++;
      end
      chk("rd_valid", rd_valid, rv_exp);
      if (rd_valid && rv_exp) begin
        chk("rd_data", rd_data, pmem[cur_addr[11:0]]);
        rv_cnt++;
        last_rdata = rd_data;
      end
      prev_st = st;
    end
  end

  int push_cyc = 0;

  task automatic push(input logic [24:0] a,
                      input logic [7:0] d,
                      input bit acc);
    wexp_t e;
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (acc) begin
      e.a = a;
      e.d = d;
      wq.push_back(e);
      pmem[a[11:0]] = d;
    end
    @(posedge clk);
    #1;
    push_cyc = cyc;
    ioctl_wr = 1'b0;
  endtask

  task automatic read_req(input logic [24:0] a);
    rd_req  = 1'b1;
    rd_addr = a;
    if (!rp_v) begin
      rp_v    = 1'b1;
      rp_addr = a;
    end
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, busy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int r0, w0, v0;
    for (int i = 0; i < 4096; i++) begin
      sd_mem[i] = 8'h00;
      pmem[i]   = 8'h00;
    end
    init = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    wr_b = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    rd_req = 1'b0;
    rd_req_b = 1'b0;
    rd_addr = '0;
    stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr", misc_addr, 0);
    chk("rst_din", misc_din, 0);
    chk("rst_rd", misc_rd, 0);
    chk("rst_we", misc_we, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_rvalid", rd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    @(posedge clk);
    #1;
    init = 1'b0;
    chk_en = 1'b1;

    // Single write
    w0 = wr_seen;
    push(25'h00010, 8'hA5, 1'b1);
    wait_idle("single_idle");
    chk("single_cnt", wr_seen - w0, 1);
    chk("single_lat", rise_cyc - push_cyc, 2);
    chk("single_hi", last_hi, 9);
    chk("single_mem", sd_mem[12'h010], 8'hA5);

    // Overflow under stall
    ioctl_download = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ioctl_download = 1'b0;
    stall = 1'b1;
    w0 = wr_seen;
    r0 = rise_cnt;
    for (int i = 0; i < 6; i++)
      push(25'h00040 + 25'(i), 8'(i), i < 5);
    @(negedge clk);
    chk("ovf_set", overflow, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("ovf_inflight", rise_cnt - r0, 1);
    stall = 1'b0;
    wait_idle("ovf_idle");
    chk("ovf_writes", wr_seen - w0, 5);
    chk("ovf_q", wq.size(), 0);
    chk("ovf_b4", sd_mem[12'h044], 8'h04);
    chk("ovf_sticky", overflow, 1);

    // Overflow clear on download rise
    ioctl_download = 1'b1;
    @(negedge clk);
    chk("ovf_hold", overflow, 1);
    @(negedge clk);
    chk("ovf_clr", overflow, 0);
    @(posedge clk);
    #1;
    ioctl_download = 1'b0;

    // Read ordering
    w0 = wr_seen;
    v0 = rv_cnt;
    push(25'h00100, 8'h11, 1'b1);
    push(25'h00101, 8'h22, 1'b1);
    read_req(25'h00101);
    wait_idle("rd_idle");
    chk("rd_writes", wr_seen - w0, 2);
    chk("rd_pulses", rv_cnt - v0, 1);
    chk("rd_value", last_rdata, 8'h22);

    // Base wrap on the second instance
    wr_b = 1'b1;
    ioctl_addr = 25'h20;
    ioctl_dout = 8'h5A;
    @(posedge clk);
    #1;
    wr_b = 1'b0;
    for (int i = 0; i < 20 && !misc_we_b; i++)
      @(negedge clk);
    chk("wrap_we", misc_we_b, 1);
    chk("wrap_addr", misc_addr_b, 25'h0000010);
    chk("wrap_din", misc_din_b, 8'h5A);
    for (int i = 0; i < 60 && busy_b; i++)
      @(negedge clk);
    chk("wrap_idle", busy_b, 0);
    chk("wrap_ovf", overflow_b, 0);
    chk("wrap_rd", misc_rd_b, 0);
    chk("wrap_rv", rd_valid_b, 0);
    chk("wrap_rdata", rd_data_b, 0);
    @(posedge clk);
    #1;

    // init while a write sits in DONE
    stall = 1'b1;
    push(25'h00200, 8'hC0, 1'b1);
    push(25'h00201, 8'hC1, 1'b1);
    push(25'h00202, 8'hC2, 1'b1);
    read_req(25'h00200);
    repeat (6) @(posedge clk);
    #1;
    chk("mid_we_pre", misc_we, 1);
    init = 1'b1;
    wq.delete();
    rp_v = 1'b0;
    @(posedge clk);
    #1;
    init = 1'b0;
    @(negedge clk);
    chk("mid_we", misc_we, 0);
    chk("mid_busy", busy, 0);
    r0 = rise_cnt;
    v0 = rv_cnt;
    stall = 1'b0;
    repeat (40) @(negedge clk);
    chk("mid_nostrobe", rise_cnt - r0, 0);
    chk("mid_norv", rv_cnt - v0, 0);
    chk("mid_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
